tl_ul_scratch_responder: RTL
============================

// Module: tl_ul_scratch_responder
// PURPOSE
//  TileLink-UL responder (manager end): accepts A-channel Get/PutFull/PutPartial, returns D-channel AccessAck/AccessAckData.
//  Backed by a local DEPTH x 32b scratch array; single-beat only (size<=2).
//  Sits at the far end of the A-channel repeater/monitor path; gives the bus monitors a live responder for checking.
// PARAMETERS
//  ADDR_W   15  A-channel address width (byte address)
//  SRC_W    7   source-ID width, echoed on D
//  DEPTH    16  scratch words (power of 2); index = a_address[2+:log2(DEPTH)]
// PORTS
//  clock       in  1      single clock, all state on posedge
//  reset_n     in  1      asynchronous, active-low reset
//  a_valid     in  1      A request valid
//  a_ready     out 1      A request accepted when a_valid&a_ready
//  a_opcode    in  3      0=PutFull 1=PutPartial 4=Get
//  a_param     in  3      must be 0; ignored
//  a_size      in  3      log2 bytes
//  a_source    in  SRC_W  request ID
//  a_address   in  ADDR_W byte address
//  a_mask      in  4      byte lanes
//  a_data      in  32     write data
//  d_valid     out 1      D response valid
//  d_ready     in  1      D response accepted when d_valid&d_ready
//  d_opcode    out 3      0=AccessAck 1=AccessAckData
//  d_size      out 3      echo of a_size
//  d_source    out SRC_W  echo of a_source
//  d_denied    out 1      request rejected (see CONFIGURATION)
//  d_data      out 32     read data (0 for AccessAck or denied)
// BEHAVIOUR
//  Reset (async, reset_n=0): d_valid=0, d_opcode/d_size/d_source/d_denied/d_data=0, scratch cleared to 0.
//  a_ready stays 0 while reset_n=0; first accept possible on the first clock edge after deassertion.
//  FSM: IDLE (no response held) / RESP (response register full).
//   IDLE --A fire--> RESP; RESP --D fire, no A fire--> IDLE; RESP --D fire & A fire--> RESP (new rsp).
//  a_ready = ~d_valid | d_ready  (one-deep skid; full throughput 1 req/cycle with d_ready=1).
//  Latency: A fire on edge N -> d_valid=1 with response fields after edge N; zero-bubble back-to-back.
//  d_* fields stable while d_valid & ~d_ready; d_valid never drops without D fire.
//  Get: d_opcode=1, d_data=scratch[idx] read at A fire (read-before-write same cycle is N/A: one req/cycle).
//  PutFull/PutPartial: scratch[idx] byte lanes with a_mask=1 written at A fire; d_opcode=0, d_data=0.
//  Get after Put to same idx on next cycle returns written data (write committed at Put fire edge).
//  Illegal = opcode not in {0,1,4}, or a_size>2: no scratch write, d_denied=1, d_opcode=1 if Get else 0, d_data=0.
//  A fire in same cycle as reset assertion: dropped; no response produced.
// CONFIGURATION
//  TL_SCRATCH_DENY_EN defined: address >= DEPTH*4 also illegal (denied, no write).
//  TL_SCRATCH_DENY_EN undefined: idx wraps modulo DEPTH, out-of-range never denied; opcode/size checks remain.
// STRUCTURE
//  Package tl_ul_pkg: A/D opcode enums, TL_DATA_W=32, TL_MASK_W=4, state typedef {IDLE,RESP}.
//  Sub-module tl_ul_scratch_ram: DEPTH x 32 byte-write array, sync write, comb read, async clear.
//  Top: FSM, legality decode, response register.
// TESTING
//  1. PutFull addr 0x8 data 0xDEADBEEF mask 0xF src 5 -> next cycle AccessAck src5 denied0; Get 0x8 -> AccessAckData 0xDEADBEEF.
//  2. PutPartial addr 0x8 mask 0x3 data 0x00001234 -> Get 0x8 returns 0xDEAD1234.
//  3. d_ready=0 for 5 cycles after Get -> a_ready=0, d_* held; d_ready=1 with new a_valid -> zero-bubble next rsp.
//  4. a_opcode=2 or a_size=3 -> d_denied=1, scratch unchanged (verify via Get).
//  5. DENY_EN: Get addr 0x40 (DEPTH=16) -> denied; without: returns scratch[0].
//  6. reset_n low while d_valid=1 -> d_valid=0 immediately; Get 0x8 after release -> 0.

Source files
------------

// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL opcode encodings, bus widths and responder state type.
package tl_ul_pkg;

  localparam int TL_DATA_W = 32;
  localparam int TL_MASK_W = 4;

  typedef enum logic [2:0] {
    A_PUT_FULL    = 3'd0,
    A_PUT_PARTIAL = 3'd1,
    A_GET         = 3'd4
  } a_op_e;

  typedef enum logic [2:0] {
    D_ACCESS_ACK      = 3'd0,
    D_ACCESS_ACK_DATA = 3'd1
  } d_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

endpackage

// File: rtl/tl_ul_scratch_ram.sv
// DEPTH x 32b scratch array: byte-lane synchronous write, combinational read,
// asynchronous clear on reset.
module tl_ul_scratch_ram
  import tl_ul_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 we,
  input  logic [IDX_W-1:0]     idx,
  input  logic [TL_MASK_W-1:0] wmask,
  input  logic [TL_DATA_W-1:0] wdata,
  output logic [TL_DATA_W-1:0] rdata
);

  logic [TL_DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      for (int b = 0; b < TL_MASK_W; b++) begin
        if (wmask[b]) begin
          mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/tl_ul_scratch_responder.sv
// TileLink-UL single-beat responder backed by a scratch array.
// Optional macro TL_SCRATCH_DENY_EN: addresses beyond the array are denied.
module tl_ul_scratch_responder
  import tl_ul_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int SRC_W  = 7,
  parameter int DEPTH  = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [2:0]           a_opcode,
  input  logic [2:0]           a_param,
  input  logic [2:0]           a_size,
  input  logic [SRC_W-1:0]     a_source,
  input  logic [ADDR_W-1:0]    a_address,
  input  logic [TL_MASK_W-1:0] a_mask,
  input  logic [TL_DATA_W-1:0] a_data,
  output logic                 d_valid,
  input  logic                 d_ready,
  output logic [2:0]           d_opcode,
  output logic [2:0]           d_size,
  output logic [SRC_W-1:0]     d_source,
  output logic                 d_denied,
  output logic [TL_DATA_W-1:0] d_data
);

  // state | meaning
  // IDLE  | no response held, d_valid low
  // RESP  | response register full, d_valid high

  localparam int IDX_W = $clog2(DEPTH);

  state_e               state_q, state_d;
  logic                 a_fire, d_fire;
  logic                 is_get, opc_ok, size_ok, range_ok, legal, we;
  logic [IDX_W-1:0]     idx;
  logic [TL_DATA_W-1:0] rdata;
  logic                 unused_bits;

  assign a_ready = reset_n & (~d_valid | d_ready);
  assign a_fire  = a_valid & a_ready;
  assign d_fire  = d_valid & d_ready;

  assign idx     = a_address[2 +: IDX_W];
  assign is_get  = (a_opcode == A_GET);
  assign opc_ok  = (a_opcode == A_PUT_FULL) | (a_opcode == A_PUT_PARTIAL) | is_get;
  assign size_ok = (a_size <= 3'd2);
`ifdef TL_SCRATCH_DENY_EN
  assign range_ok = ~|a_address[ADDR_W-1:2+IDX_W];
`else
  assign range_ok = 1'b1;
`endif
  assign legal   = opc_ok & size_ok & range_ok;
  assign we      = a_fire & legal & ~is_get;

  assign unused_bits = ^{a_param, a_address[1:0], a_address[ADDR_W-1:2+IDX_W]};

  tl_ul_scratch_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (we),
    .idx     (idx),
    .wmask   (a_mask),
    .wdata   (a_data),
    .rdata   (rdata)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (a_fire) state_d = RESP;
      RESP:    if (d_fire && !a_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    d_valid = (state_q == RESP);
  end

  // Fields load only on A fire, so they stay put while the response is stalled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      d_opcode <= '0;
      d_size   <= '0;
      d_source <= '0;
      d_denied <= 1'b0;
      d_data   <= '0;
    end else if (a_fire) begin
      d_opcode <= is_get ? D_ACCESS_ACK_DATA : D_ACCESS_ACK;
      d_size   <= a_size;
      d_source <= a_source;
      d_denied <= ~legal;
      d_data   <= (legal && is_get) ? rdata : '0;
    end
  end

endmodule
